button_event_ctrl: RTL
======================

Name: button_event_ctrl

Overview:
Sits between the mouse-region button decoder and the game state machine. It qualifies the decoder's level outputs (deal, hit, stand, start, player1, player2) into one-cycle debounced events with a post-release lockout, so one physical click produces exactly one event. It also arbitrates the shared hit/stand buttons between player 1 and player 2 in two-player mode, tracking turn ownership and routing each event to the active player.

Parameters:
HOLD_CYCLES, 4, consecutive high samples required to qualify a press (>=1; 65_000 = 1 ms at 65 MHz in the top level)
LOCKOUT_CYCLES, 8, cycles after release during which all inputs are ignored (>=1; 6_500_000 in the top level)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
btn_deal  input  1  level from region decoder
btn_hit  input  1  level from region decoder
btn_stand  input  1  level from region decoder
btn_start  input  1  level from region decoder
btn_player1  input  1  level, one-player mode select
btn_player2  input  1  level, two-player mode select
deal_evt  output  1  one-cycle pulse
start_evt  output  1  one-cycle pulse
p1_hit  output  1  one-cycle pulse, hit for player 1
p1_stand  output  1  one-cycle pulse, stand for player 1
p2_hit  output  1  one-cycle pulse, hit for player 2
p2_stand  output  1  one-cycle pulse, stand for player 2
mode_2p  output  1  0 = one player, 1 = two players
active_player  output  1  0 = player 1 turn, 1 = player 2 turn
busy  output  1  high whenever state != IDLE

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state IDLE, counters 0, all pulse outputs 0, mode_2p 0, active_player 0, busy 0. Reset mid-press or mid-lockout aborts with no event.
- Input selection: if several inputs are high, priority is deal > hit > stand > start > player1 > player2. The selected code is captured on IDLE exit.
- FSM:
  - IDLE: any input high -> QUALIFY. Capture the code; cnt = 1.
  - QUALIFY: if the captured input is low, or a different higher-priority input wins -> IDLE, no event. Otherwise increment cnt.
  - QUALIFY, release path: the edge taking the HOLD_CYCLES-th consecutive high sample registers the event and moves to WAIT_RELEASE. With HOLD_CYCLES=1, this happens on the IDLE-exit edge.
  - Event timing: the pulse is high for exactly the one cycle after that edge.
  - WAIT_RELEASE: all six inputs low -> LOCKOUT, cnt = 0.
  - LOCKOUT: count to LOCKOUT_CYCLES-1. Inputs are ignored while counting. At terminal count: all low -> IDLE; any high -> WAIT_RELEASE.
- Routing (applied on the pulse cycle, registered with the pulse):
  - start: start_evt; active_player <= 0.
  - deal: deal_evt; active_player <= 0.
  - player1: mode_2p <= 0, active_player <= 0. No pulse.
  - player2: mode_2p <= 1, active_player <= 0. No pulse.
  - hit: p2_hit if mode_2p && active_player, else p1_hit.
  - stand: p2_stand if mode_2p && active_player, else p1_stand. If mode_2p && !active_player, then active_player <= 1. Stand by player 2 leaves active_player at 1.
- At most one pulse output is high in any cycle. No event is lost or duplicated for a single held press of any length.
- Counter widths: $clog2(max(HOLD_CYCLES, LOCKOUT_CYCLES)+1). Counters saturate and never wrap.

Test Plan:
- Reset/idle: rst 3 cycles with inputs low -> all outputs 0, busy 0, mode_2p 0, active_player 0.
- Qualified press: btn_hit high from edge 10 for 20 cycles, HOLD=4 -> p1_hit high only between edges 13 and 14. Exactly one pulse; busy high from edge 10. IDLE 8 cycles after release.
- Glitch rejection: btn_deal high for 3 edges then low -> no deal_evt, busy returns to 0.
- Lockout: stand press, release, re-press btn_hit 2 cycles after release and hold 4 cycles -> no p1_hit. After lockout with hit still held -> WAIT_RELEASE, still no event.
- Two-player turns: player2 click, then hit -> p1_hit. Then stand -> p1_stand with active_player -> 1. Then hit -> p2_hit. Then deal -> deal_evt with active_player -> 0.
- Priority and reset abort: btn_deal and btn_stand high together -> only deal_evt. Assert rst in LOCKOUT -> IDLE immediately, with no pulses while rst is high.

Source files
------------

// File: rtl/button_event_ctrl_if.sv
// Button-decoder levels in, qualified game events out.
// The master side is the decoder/game logic; the slave side is the event controller.
interface button_event_ctrl_if;
    logic btn_deal;
    logic btn_hit;
    logic btn_stand;
    logic btn_start;
    logic btn_player1;
    logic btn_player2;
    logic deal_evt;
    logic start_evt;
    logic p1_hit;
    logic p1_stand;
    logic p2_hit;
    logic p2_stand;
    logic mode_2p;
    logic active_player;
    logic busy;

    modport master (
        output btn_deal, btn_hit, btn_stand, btn_start, btn_player1, btn_player2,
        input  deal_evt, start_evt, p1_hit, p1_stand, p2_hit, p2_stand,
        input  mode_2p, active_player, busy
    );

    modport slave (
        input  btn_deal, btn_hit, btn_stand, btn_start, btn_player1, btn_player2,
        output deal_evt, start_evt, p1_hit, p1_stand, p2_hit, p2_stand,
        output mode_2p, active_player, busy
    );
endinterface

// File: rtl/button_event_ctrl.sv
// Turns raw button levels into single debounced event pulses with a post-release lockout,
// and routes hit/stand to whichever player currently owns the turn.
module button_event_ctrl #(
    parameter int HOLD_CYCLES    = 4,
    parameter int LOCKOUT_CYCLES = 8
) (
    input logic               clk,
    input logic               rst,
    button_event_ctrl_if.slave bus
);
    localparam int MAX_CNT = (HOLD_CYCLES > LOCKOUT_CYCLES) ? HOLD_CYCLES : LOCKOUT_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCKOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_CNT);

    typedef enum logic [1:0] {IDLE, QUALIFY, WAIT_RELEASE, LOCKOUT} state_t;
    typedef enum logic [2:0] {
        CODE_NONE, CODE_DEAL, CODE_HIT, CODE_STAND, CODE_START, CODE_P1, CODE_P2
    } code_t;

    state_t        state_q, state_d;
    code_t         code_q, code_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          deal_evt_q, deal_evt_d;
    logic          start_evt_q, start_evt_d;
    logic          p1_hit_q, p1_hit_d;
    logic          p1_stand_q, p1_stand_d;
    logic          p2_hit_q, p2_hit_d;
    logic          p2_stand_q, p2_stand_d;
    logic          mode_2p_q, mode_2p_d;
    logic          active_player_q, active_player_d;
    logic          busy_q, busy_d;

    code_t         sel;
    logic          any_high;
    logic          captured_high;
    logic          fire;
    logic [CW-1:0] cnt_inc;

    always_comb begin
        sel = CODE_NONE;
        if (bus.btn_deal)         sel = CODE_DEAL;
        else if (bus.btn_hit)     sel = CODE_HIT;
        else if (bus.btn_stand)   sel = CODE_STAND;
        else if (bus.btn_start)   sel = CODE_START;
        else if (bus.btn_player1) sel = CODE_P1;
        else if (bus.btn_player2) sel = CODE_P2;
    end

    assign any_high = bus.btn_deal | bus.btn_hit | bus.btn_stand |
                      bus.btn_start | bus.btn_player1 | bus.btn_player2;
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        captured_high = 1'b0;
        case (code_q)
            CODE_DEAL:  captured_high = bus.btn_deal;
            CODE_HIT:   captured_high = bus.btn_hit;
            CODE_STAND: captured_high = bus.btn_stand;
            CODE_START: captured_high = bus.btn_start;
            CODE_P1:    captured_high = bus.btn_player1;
            CODE_P2:    captured_high = bus.btn_player2;
            default:    captured_high = 1'b0;
        endcase
    end

    // While qualifying, the winner stays equal to the captured code only if nothing higher arrived.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        fire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_high) begin
                    code_d = sel;
                    cnt_d  = CW'(1);
                    if (HOLD_CYCLES == 1) begin
                        fire    = 1'b1;
                        state_d = WAIT_RELEASE;
                    end else begin
                        state_d = QUALIFY;
                    end
                end
            end
            QUALIFY: begin
                if (!captured_high || sel != code_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == HOLD_LAST) begin
                        fire    = 1'b1;
                        state_d = WAIT_RELEASE;
                    end
                end
            end
            WAIT_RELEASE: begin
                if (!any_high) begin
                    state_d = LOCKOUT;
                    cnt_d   = '0;
                end
            end
            LOCKOUT: begin
                if (cnt_q == LOCK_LAST) begin
                    state_d = any_high ? WAIT_RELEASE : IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A qualified stand in two-player mode hands the turn from player 1 to player 2.
    always_comb begin
        deal_evt_d      = 1'b0;
        start_evt_d     = 1'b0;
        p1_hit_d        = 1'b0;
        p1_stand_d      = 1'b0;
        p2_hit_d        = 1'b0;
        p2_stand_d      = 1'b0;
        mode_2p_d       = mode_2p_q;
        active_player_d = active_player_q;
        busy_d          = (state_d != IDLE);
        if (fire) begin
            case (sel)
                CODE_DEAL: begin
                    deal_evt_d      = 1'b1;
                    active_player_d = 1'b0;
                end
                CODE_START: begin
                    start_evt_d     = 1'b1;
                    active_player_d = 1'b0;
                end
                CODE_P1: begin
                    mode_2p_d       = 1'b0;
                    active_player_d = 1'b0;
                end
                CODE_P2: begin
                    mode_2p_d       = 1'b1;
                    active_player_d = 1'b0;
                end
                CODE_HIT: begin
                    if (mode_2p_q && active_player_q) p2_hit_d = 1'b1;
                    else                              p1_hit_d = 1'b1;
                end
                CODE_STAND: begin
                    if (mode_2p_q && active_player_q) begin
                        p2_stand_d = 1'b1;
                    end else begin
                        p1_stand_d = 1'b1;
                        if (mode_2p_q) active_player_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            code_q          <= CODE_NONE;
            cnt_q           <= '0;
            deal_evt_q      <= 1'b0;
            start_evt_q     <= 1'b0;
            p1_hit_q        <= 1'b0;
            p1_stand_q      <= 1'b0;
            p2_hit_q        <= 1'b0;
            p2_stand_q      <= 1'b0;
            mode_2p_q       <= 1'b0;
            active_player_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            code_q          <= code_d;
            cnt_q           <= cnt_d;
            deal_evt_q      <= deal_evt_d;
            start_evt_q     <= start_evt_d;
            p1_hit_q        <= p1_hit_d;
            p1_stand_q      <= p1_stand_d;
            p2_hit_q        <= p2_hit_d;
            p2_stand_q      <= p2_stand_d;
            mode_2p_q       <= mode_2p_d;
            active_player_q <= active_player_d;
            busy_q          <= busy_d;
        end
    end

    assign bus.deal_evt      = deal_evt_q;
    assign bus.start_evt     = start_evt_q;
    assign bus.p1_hit        = p1_hit_q;
    assign bus.p1_stand      = p1_stand_q;
    assign bus.p2_hit        = p2_hit_q;
    assign bus.p2_stand      = p2_stand_q;
    assign bus.mode_2p       = mode_2p_q;
    assign bus.active_player = active_player_q;
    assign bus.busy          = busy_q;
endmodule
